mdio_init_sequencer: RTL and testbench
======================================

Name: mdio_init_sequencer

Overview:
- Boot-time PHY configuration controller that drives the MDIO write engine.
- After a power-on delay, walks a table of register writes (reg_addr, data) and issues each one to the write engine with a write_en/busy handshake.
- Inserts an inter-write gap between entries and reports done or error.
- Sits between the system reset/clocking logic and the MDIO write engine. Runs entirely in the MDC domain.

Parameters:
- NUM_ENTRIES, 8: number of table entries executed (1..32).
- PHY_ADDR, 5'd1: PHY address used for every write.
- POR_CYCLES, 25000: MDC cycles to wait after reset release before the first write (10 ms at 2.5 MHz).
- GAP_CYCLES, 16: idle MDC cycles between the busy fall of one write and the write_en of the next.
- ACK_TIMEOUT, 8: cycles allowed from the write_en pulse to busy rising.

Ports:
- mdc  in  1  MDC clock; all logic runs on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  re-run request; level sampled in S_IDLE, S_DONE and S_ERROR.
- tbl_idx  out  5  current table index, 0..NUM_ENTRIES-1.
- tbl_entry  in  22  combinational table read data for tbl_idx: [21] delay flag, [20:16] reg_addr, [15:0] data.
- wr_phy_addr  out  5  to the writer's phy_addr.
- wr_reg_addr  out  5  to the writer's reg_addr; registered.
- wr_data  out  16  to the writer's data; registered.
- wr_en  out  1  to the writer's write_en; single-cycle pulse.
- wr_busy  in  1  from the writer's busy.
- init_done  out  1  high in S_DONE.
- init_err  out  1  high in S_ERROR.
- err_idx  out  5  table index that timed out; held until the next run starts.

Behaviour:
- Reset values: tbl_idx=0, wr_reg_addr=0, wr_data=0, wr_en=0, init_done=0, init_err=0, err_idx=0, state=S_POR, counter=0.
- wr_phy_addr is constant PHY_ADDR.
- States and transitions:
  - S_POR: counter counts up. At POR_CYCLES-1 go to S_LOAD with tbl_idx=0. This is the auto-start; no start pulse is needed.
  - S_IDLE: entered only after an abort. If start=1, go to S_LOAD with tbl_idx=0.
  - S_LOAD: register tbl_entry[20:16] into wr_reg_addr and [15:0] into wr_data, then go to S_ISSUE. The table is read exactly one cycle after tbl_idx changes.
  - S_ISSUE: wr_en=1 for exactly this cycle, clear the counter, go to S_WACK.
  - S_WACK:
    - If wr_busy=1, go to S_WBUSY.
    - Else, once the counter reaches ACK_TIMEOUT-1, go to S_ERROR with err_idx=tbl_idx.
  - S_WBUSY: wait for wr_busy=0, then clear the counter and go to S_GAP.
  - S_GAP: count GAP_CYCLES cycles.
    - If tbl_idx==NUM_ENTRIES-1, go to S_DONE.
    - Else increment tbl_idx and go to S_LOAD.
  - S_DONE: init_done=1. If start=1, clear init_done, set tbl_idx=0 and go to S_LOAD.
  - S_ERROR: init_err=1. If start=1, clear init_err and err_idx, set tbl_idx=0 and go to S_LOAD.
- Latency: wr_en rises 2 cycles after tbl_idx updates.
- Back-to-back spacing: wr_en pulses are separated by the writer's frame length, plus GAP_CYCLES, plus 3 cycles.
- Boundary conditions:
  - wr_busy already high when entering S_WACK: accepted as the acknowledge.
  - start asserted during S_POR, S_LOAD, S_ISSUE, S_WACK, S_WBUSY or S_GAP: ignored.
  - NUM_ENTRIES=1: go straight from S_GAP to S_DONE.
  - tbl_idx never exceeds NUM_ENTRIES-1 and never wraps.
  - RST_N low at any time: immediate return to the reset values, restart at S_POR, and wr_en drops asynchronously.
  - A reset in the middle of a write does not wait for the writer.
- Counter: 16 bits wide. POR_CYCLES must be below 65536.

Optional Feature:
- Macro: MDIO_INIT_DELAY_ENTRY_EN.
- Defined:
  - In S_LOAD, an entry with tbl_entry[21]=1 is a delay entry: no write is issued and no wr_en pulse occurs.
  - Go to S_DLY, which waits tbl_entry[15:0]*16 cycles (20-bit counter), then runs the normal S_GAP/advance logic.
  - A delay count of 0 means the delay phase lasts 0 cycles.
- Not defined: bit [21] is ignored and every entry is written normally. S_DLY and its counter are not synthesised.

Test Plan:
- Reset release, POR_CYCLES=20, NUM_ENTRIES=3, table {00/1140, 04/01E1, 00/1340}, writer model with busy for 66 cycles:
  - Expect the first wr_en 22 cycles after release.
  - Expect three wr_en pulses carrying reg/data in table order, wr_phy_addr=1, then init_done=1.
- Writer model that never raises busy, ACK_TIMEOUT=8: expect init_err=1 and err_idx=0 exactly 8 cycles after wr_en, no further wr_en, init_done=0.
- While in S_DONE, pulse start for 1 cycle: expect init_done to fall, tbl_idx=0, and the sequence to repeat identically.
- RST_N low during the second write's S_WBUSY: expect immediate reset values, tbl_idx=0, and a full POR wait before the first wr_en reappears.
- GAP_CYCLES=16: measure from the busy fall to the next wr_en and expect exactly 18 cycles. Pulse start during S_WACK and expect no effect.
- With MDIO_INIT_DELAY_ENTRY_EN: the entry at index 1 is 1_00000_0004.
  - Expect no wr_en for index 1.
  - Expect a delay of 64 cycles plus GAP_CYCLES before the index-2 write.
  - Without the macro, the same entry is written with reg=0 and data=0004.

Source files
------------

// File: rtl/mdio_init_sequencer.sv
// Boot-time PHY configuration sequencer: after a power-on wait it walks a table of
// MDIO register writes through the write engine. Optional delay entries: MDIO_INIT_DELAY_ENTRY_EN.
module mdio_init_sequencer #(
    parameter int         NUM_ENTRIES = 8,
    parameter logic [4:0] PHY_ADDR    = 5'd1,
    parameter int         POR_CYCLES  = 25000,
    parameter int         GAP_CYCLES  = 16,
    parameter int         ACK_TIMEOUT = 8
) (
    input  logic        mdc,
    input  logic        RST_N,
    input  logic        start,
    output logic [4:0]  tbl_idx,
    input  logic [21:0] tbl_entry,
    output logic [4:0]  wr_phy_addr,
    output logic [4:0]  wr_reg_addr,
    output logic [15:0] wr_data,
    output logic        wr_en,
    input  logic        wr_busy,
    output logic        init_done,
    output logic        init_err,
    output logic [4:0]  err_idx
);

    localparam logic [15:0] POR_LAST = 16'(POR_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [4:0]  IDX_LAST = 5'(NUM_ENTRIES - 1);

    typedef enum logic [3:0] {
        S_POR,
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WACK,
        S_WBUSY,
        S_GAP,
        S_DONE,
`ifdef MDIO_INIT_DELAY_ENTRY_EN
        S_DLY,
`endif
        S_ERROR
    } state_t;

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [4:0]  idx_d;
    logic [4:0]  reg_d;
    logic [15:0] data_d;
    logic        wr_en_d;
    logic        done_d;
    logic        err_d;
    logic [4:0]  err_idx_d;

`ifdef MDIO_INIT_DELAY_ENTRY_EN
    logic [19:0] dcnt, dcnt_d;
`else
    logic        unused_dly_flag;
    assign unused_dly_flag = tbl_entry[21];
`endif

    assign wr_phy_addr = PHY_ADDR;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        idx_d     = tbl_idx;
        reg_d     = wr_reg_addr;
        data_d    = wr_data;
        wr_en_d   = 1'b0;
        done_d    = init_done;
        err_d     = init_err;
        err_idx_d = err_idx;
`ifdef MDIO_INIT_DELAY_ENTRY_EN
        dcnt_d    = dcnt;
`endif
        case (state)
            S_POR: begin
                if (cnt == POR_LAST) begin
                    state_d = S_LOAD;
                    idx_d   = 5'd0;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = 5'd0;
                end
            end
            S_LOAD: begin
                reg_d   = tbl_entry[20:16];
                data_d  = tbl_entry[15:0];
                state_d = S_ISSUE;
`ifdef MDIO_INIT_DELAY_ENTRY_EN
                // Delay entries skip the writer; a zero count goes straight to the gap.
                if (tbl_entry[21]) begin
                    cnt_d  = 16'd0;
                    dcnt_d = 20'd0;
                    state_d = (tbl_entry[15:0] == 16'd0) ? S_GAP : S_DLY;
                end
`endif
            end
            S_ISSUE: begin
                wr_en_d = 1'b1;
                cnt_d   = 16'd0;
                state_d = S_WACK;
            end
            S_WACK: begin
                if (wr_busy) begin
                    state_d = S_WBUSY;
                end else if (cnt == ACK_LAST) begin
                    state_d   = S_ERROR;
                    err_d     = 1'b1;
                    err_idx_d = tbl_idx;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            S_WBUSY: begin
                if (!wr_busy) begin
                    cnt_d   = 16'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    if (tbl_idx == IDX_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = tbl_idx + 5'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
`ifdef MDIO_INIT_DELAY_ENTRY_EN
            S_DLY: begin
                if (dcnt == {wr_data, 4'h0} - 20'd1) begin
                    cnt_d   = 16'd0;
                    state_d = S_GAP;
                end else begin
                    dcnt_d = dcnt + 20'd1;
                end
            end
`endif
            S_DONE: begin
                if (start) begin
                    done_d  = 1'b0;
                    idx_d   = 5'd0;
                    state_d = S_LOAD;
                end
            end
            S_ERROR: begin
                if (start) begin
                    err_d     = 1'b0;
                    err_idx_d = 5'd0;
                    idx_d     = 5'd0;
                    state_d   = S_LOAD;
                end
            end
            default: state_d = S_POR;
        endcase
    end

    // Reset clears wr_en asynchronously so a pending pulse never reaches the writer.
    always_ff @(posedge mdc or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_POR;
            cnt         <= 16'd0;
            tbl_idx     <= 5'd0;
            wr_reg_addr <= 5'd0;
            wr_data     <= 16'd0;
            wr_en       <= 1'b0;
            init_done   <= 1'b0;
            init_err    <= 1'b0;
            err_idx     <= 5'd0;
`ifdef MDIO_INIT_DELAY_ENTRY_EN
            dcnt        <= 20'd0;
`endif
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            tbl_idx     <= idx_d;
            wr_reg_addr <= reg_d;
            wr_data     <= data_d;
            wr_en       <= wr_en_d;
            init_done   <= done_d;
            init_err    <= err_d;
            err_idx     <= err_idx_d;
`ifdef MDIO_INIT_DELAY_ENTRY_EN
            dcnt        <= dcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mdio_init_sequencer.sv
// Directed bench for mdio_init_sequencer with a behavioural MDIO writer (66-cycle busy).
// Build with MDIO_INIT_DELAY_ENTRY_EN defined to exercise delay entries.
module tb_mdio_init_sequencer;

    logic        mdc = 1'b0;
    logic        RST_N;
    logic        start;
    logic [4:0]  tbl_idx;
    logic [21:0] tbl_entry;
    logic [4:0]  wr_phy_addr;
    logic [4:0]  wr_reg_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        wr_busy;
    logic        init_done;
    logic        init_err;
    logic [4:0]  err_idx;

    logic [21:0] tbl [0:31];
    int          cyc = 0;
    int          fall_cyc = 0;
    int          n_wr = 0;
    bit          writer_on;
    int          n_tests = 0;
    int          n_fail = 0;

    assign tbl_entry = tbl[tbl_idx];

    mdio_init_sequencer #(
        .NUM_ENTRIES(3),
        .PHY_ADDR   (5'd1),
        .POR_CYCLES (20),
        .GAP_CYCLES (16),
        .ACK_TIMEOUT(8)
    ) dut (
        .mdc        (mdc),
        .RST_N      (RST_N),
        .start      (start),
        .tbl_idx    (tbl_idx),
        .tbl_entry  (tbl_entry),
        .wr_phy_addr(wr_phy_addr),
        .wr_reg_addr(wr_reg_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_busy    (wr_busy),
        .init_done  (init_done),
        .init_err   (init_err),
        .err_idx    (err_idx)
    );

    always #5 mdc = ~mdc;

    always @(posedge mdc) cyc <= cyc + 1;

    always @(negedge mdc) if (wr_en) n_wr <= n_wr + 1;

    // Writer: busy rises half a cycle after it sees write_en and stays high 66 cycles.
    initial begin
        wr_busy = 1'b0;
        forever begin
            @(negedge mdc);
            if (wr_en && writer_on) begin
                wr_busy = 1'b1;
                for (int i = 0; i < 66; i++) begin
                    @(negedge mdc);
                    if (!RST_N) break;
                end
                wr_busy  = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_wr(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge mdc);
            if (wr_en) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("wr_en_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_flag(input bit want_err, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge mdc);
            if ((!want_err && init_done) || (want_err && init_err)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check(want_err ? "err_timeout" : "done_timeout", 32'd0, 32'd1);
    endtask

    // Writes 2 and 3 of the standard table plus completion, given the cycle of write 1.
    task automatic run_rest(input int t0, input bit poke_start);
        int t1, t2, td;
        if (poke_start) begin
            start = 1'b1;
            @(negedge mdc);
            start = 1'b0;
        end
        wait_wr(200, t1);
        check("spacing_1", t1 - t0, 85);
        check("gap_1", t1 - (fall_cyc + 1), 18);
        check("reg_1", wr_reg_addr, 5'h04);
        check("data_1", wr_data, 16'h01E1);
        check("idx_1", tbl_idx, 5'd1);
        wait_wr(200, t2);
        check("spacing_2", t2 - t1, 85);
        check("reg_2", wr_reg_addr, 5'h00);
        check("data_2", wr_data, 16'h1340);
        check("idx_2", tbl_idx, 5'd2);
        wait_flag(1'b0, 200, td);
        check("done_lat", td - t2, 83);
        check("err_low", init_err, 1'b0);
    endtask

    initial begin
        int rel, t, t2, te, cs, nw;
        RST_N     = 1'b0;
        start     = 1'b0;
        writer_on = 1'b1;
        for (int i = 0; i < 32; i++) tbl[i] = 22'h0;
        tbl[0] = {1'b0, 5'h00, 16'h1140};
        tbl[1] = {1'b0, 5'h04, 16'h01E1};
        tbl[2] = {1'b0, 5'h00, 16'h1340};
        repeat (3) @(negedge mdc);
        check("rst_idx", tbl_idx, 5'd0);
        check("rst_reg", wr_reg_addr, 5'd0);
        check("rst_data", wr_data, 16'd0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_done", init_done, 1'b0);
        check("rst_err", init_err, 1'b0);
        check("rst_err_idx", err_idx, 5'd0);
        check("phy_addr", wr_phy_addr, 5'd1);

        // Auto-start after POR; a start pulse during the POR wait is ignored.
        RST_N = 1'b1;
        rel   = cyc;
        repeat (4) @(negedge mdc);
        start = 1'b1;
        @(negedge mdc);
        start = 1'b0;
        wait_wr(40, t);
        check("por_latency", t - rel, 22);
        check("reg_0", wr_reg_addr, 5'h00);
        check("data_0", wr_data, 16'h1140);
        check("phy_at_wr", wr_phy_addr, 5'd1);
        run_rest(t, 1'b1);

        // Re-run from S_DONE.
        start = 1'b1;
        cs    = cyc;
        @(negedge mdc);
        start = 1'b0;
        check("done_cleared", init_done, 1'b0);
        check("restart_idx", tbl_idx, 5'd0);
        wait_wr(10, t);
        check("restart_lat", t - cs, 3);
        check("restart_data", wr_data, 16'h1140);
        run_rest(t, 1'b0);

        // Reset while the second write is busy.
        start = 1'b1;
        @(negedge mdc);
        start = 1'b0;
        wait_wr(10, t);
        wait_wr(200, t);
        repeat (10) @(negedge mdc);
        @(posedge mdc);
        #2 RST_N = 1'b0;
        #1;
        check("midwr_idx", tbl_idx, 5'd0);
        check("midwr_reg", wr_reg_addr, 5'd0);
        check("midwr_data", wr_data, 16'd0);
        repeat (3) @(negedge mdc);
        RST_N = 1'b1;
        rel   = cyc;
        wait_wr(40, t);
        check("por_again", t - rel, 22);
        // wr_en must drop as soon as reset asserts.
        RST_N = 1'b0;
        #1;
        check("async_wr_en", wr_en, 1'b0);
        repeat (3) @(negedge mdc);
        RST_N = 1'b1;
        rel   = cyc;
        wait_wr(40, t);
        check("por_third", t - rel, 22);

        // Writer stops answering after the first write: timeout on index 1.
        repeat (5) @(negedge mdc);
        writer_on = 1'b0;
        wait_wr(200, t2);
        check("to_reg", wr_reg_addr, 5'h04);
        wait_flag(1'b1, 20, te);
        check("to_lat", te - t2, 8);
        check("to_err_idx", err_idx, 5'd1);
        check("to_done", init_done, 1'b0);
        nw = n_wr;
        repeat (100) @(negedge mdc);
        check("to_no_wr", n_wr, nw);
        check("to_err_held", init_err, 1'b1);
        writer_on = 1'b1;
        start = 1'b1;
        cs    = cyc;
        @(negedge mdc);
        start = 1'b0;
        check("err_cleared", init_err, 1'b0);
        check("err_idx_cleared", err_idx, 5'd0);
        wait_wr(10, t);
        check("err_restart_lat", t - cs, 3);
        run_rest(t, 1'b0);

        // Index 1 becomes a delay entry of 4*16 cycles.
        tbl[1] = {1'b1, 5'h00, 16'h0004};
        RST_N = 1'b0;
        repeat (2) @(negedge mdc);
        RST_N = 1'b1;
        rel   = cyc;
        wait_wr(40, t);
        check("dly_first", t - rel, 22);
`ifdef MDIO_INIT_DELAY_ENTRY_EN
        wait_wr(300, t2);
        check("dly_spacing", t2 - t, 166);
        check("dly_idx", tbl_idx, 5'd2);
        check("dly_data", wr_data, 16'h1340);
        wait_flag(1'b0, 200, te);
        check("dly_done_lat", te - t2, 83);
`else
        wait_wr(200, t2);
        check("nodly_spacing", t2 - t, 85);
        check("nodly_reg", wr_reg_addr, 5'h00);
        check("nodly_data", wr_data, 16'h0004);
        wait_wr(200, t);
        check("nodly_data2", wr_data, 16'h1340);
        wait_flag(1'b0, 200, te);
        check("nodly_done_lat", te - t, 83);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
